// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: round-robin IF/LSB arbitration, 1/2/4-byte split, little-endian reassembly.
// Define MEM_CTRL_IO_STALL_EN to hold IO-region byte writes while the UART buffer is full.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rollback_in,
  input  logic                  io_buffer_full_in,
  input  logic                  if_valid_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsb_valid_in,
  input  logic                  lsb_wr_in,
  input  logic [1:0]            lsb_size_in,
  input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
  input  logic [31:0]           lsb_data_in,
  output logic                  lsb_done_out,
  output logic [31:0]           lsb_data_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic io_stall(input logic [ADDR_WIDTH-1:0] a, input logic full);
    return (a[17:16] == 2'b11) && full;
  endfunction

  logic io_full_s;
`ifdef MEM_CTRL_IO_STALL_EN
  assign io_full_s = io_buffer_full_in;
`else
  logic unused_io_s;
  assign io_full_s   = 1'b0;
  assign unused_io_s = io_buffer_full_in;
`endif

  state_t                state_r, state_s;
  logic [2:0]            cnt_r, cnt_s, cnt_inc_s;
  logic [1:0]            last_r, last_s, cap_idx_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s, next_a_s;
  logic [31:0]           data_r, data_s, buf_r, buf_s;
  logic                  req_lsb_r, req_lsb_s, next_lsb_r, next_lsb_s, grant_lsb_s;
  logic [ADDR_WIDTH-1:0] mem_a_r, mem_a_s;
  logic [7:0]            mem_dout_r, mem_dout_s;
  logic                  mem_wr_r, mem_wr_s, if_done_r, if_done_s, lsb_done_r, lsb_done_s;
  logic [31:0]           if_data_r, if_data_s, lsb_data_r, lsb_data_s;

  // Next-state, byte sequencing and completion logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_s      = last_r;
    addr_s      = addr_r;
    data_s      = data_r;
    buf_s       = buf_r;
    req_lsb_s   = req_lsb_r;
    next_lsb_s  = next_lsb_r;
    grant_lsb_s = 1'b0;
    mem_a_s     = mem_a_r;
    mem_dout_s  = mem_dout_r;
    mem_wr_s    = 1'b0;
    if_done_s   = 1'b0;
    lsb_done_s  = 1'b0;
    if_data_s   = if_data_r;
    lsb_data_s  = lsb_data_r;
    cnt_inc_s   = cnt_r + 3'd1;
    next_a_s    = addr_r + ADDR_WIDTH'(cnt_inc_s);
    // read data lags its address by one cycle, so the byte landing now is cnt-1
    cap_idx_s   = cnt_r[1:0] - 2'd1;
    case (state_r)
      IDLE: begin
        if (!rollback_in && (if_valid_in || lsb_valid_in)) begin
          grant_lsb_s = lsb_valid_in && (!if_valid_in || next_lsb_r);
          req_lsb_s   = grant_lsb_s;
          next_lsb_s  = !grant_lsb_s;
          cnt_s       = 3'd0;
          buf_s       = 32'd0;
          if (grant_lsb_s) begin
            addr_s = lsb_addr_in;
            last_s = last_idx(lsb_size_in);
            data_s = lsb_data_in;
          end else begin
            addr_s = if_addr_in;
            last_s = 2'd3;
            data_s = 32'd0;
          end
          mem_a_s    = addr_s;
          mem_dout_s = data_s[7:0];
          if (grant_lsb_s && lsb_wr_in) begin
            state_s  = WRITE;
            mem_wr_s = !io_stall(addr_s, io_full_s);
          end else begin
            state_s  = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (rollback_in) begin
          state_s = IDLE;
        end else begin
          if (cnt_r != 3'd0) begin
            buf_s[{cap_idx_s, 3'b000} +: 8] = mem_din_in;
          end else begin
            buf_s = buf_r;
          end
          if (cnt_r == ({1'b0, last_r} + 3'd1)) begin
            state_s = IDLE;
            if (req_lsb_r) begin
              lsb_done_s = 1'b1;
              lsb_data_s = buf_s;
            end else begin
              if_done_s  = 1'b1;
              if_data_s  = buf_s;
            end
          end else begin
            cnt_s = cnt_inc_s;
            if (cnt_inc_s <= {1'b0, last_r}) begin
              mem_a_s = next_a_s;
            end else begin
              mem_a_s = mem_a_r;
            end
          end
        end
      end
      WRITE: begin
        // a byte is only retired once it has actually gone out with mem_wr high
        if (mem_wr_r) begin
          if (cnt_r[1:0] == last_r) begin
            state_s    = IDLE;
            lsb_done_s = 1'b1;
          end else begin
            cnt_s      = cnt_inc_s;
            mem_a_s    = next_a_s;
            mem_dout_s = byte_of(data_r, cnt_inc_s[1:0]);
            mem_wr_s   = !io_stall(next_a_s, io_full_s);
          end
        end else begin
          mem_wr_s = !io_stall(mem_a_r, io_full_s);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      last_r     <= 2'd0;
      addr_r     <= '0;
      data_r     <= 32'd0;
      buf_r      <= 32'd0;
      req_lsb_r  <= 1'b0;
      next_lsb_r <= 1'b0;
      mem_a_r    <= '0;
      mem_dout_r <= 8'd0;
      mem_wr_r   <= 1'b0;
      if_done_r  <= 1'b0;
      lsb_done_r <= 1'b0;
      if_data_r  <= 32'd0;
      lsb_data_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      last_r     <= last_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      buf_r      <= buf_s;
      req_lsb_r  <= req_lsb_s;
      next_lsb_r <= next_lsb_s;
      mem_a_r    <= mem_a_s;
      mem_dout_r <= mem_dout_s;
      mem_wr_r   <= mem_wr_s;
      if_done_r  <= if_done_s;
      lsb_done_r <= lsb_done_s;
      if_data_r  <= if_data_s;
      lsb_data_r <= lsb_data_s;
    end
  end

  assign mem_a_out    = mem_a_r;
  assign mem_dout_out = mem_dout_r;
  assign mem_wr_out   = mem_wr_r;
  assign if_done_out  = if_done_r;
  assign if_data_out  = if_data_r;
  assign lsb_done_out = lsb_done_r;
  assign lsb_data_out = lsb_data_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a 4 KiB byte RAM model (address bits [11:0]).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rollback, io_full;
  logic        if_valid, if_done, lsb_valid, lsb_wr, lsb_done, mem_wr;
  logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
  logic [1:0]  lsb_size;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  ram [0:4095];
  logic        ram_clr;
  int          wr_total = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rollback_in(rollback), .io_buffer_full_in(io_full),
    .if_valid_in(if_valid), .if_addr_in(if_addr), .if_done_out(if_done), .if_data_out(if_data),
    .lsb_valid_in(lsb_valid), .lsb_wr_in(lsb_wr), .lsb_size_in(lsb_size), .lsb_addr_in(lsb_addr),
    .lsb_data_in(lsb_wdata), .lsb_done_out(lsb_done), .lsb_data_out(lsb_rdata),
    .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a), .mem_wr_out(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM model: write on mem_wr, read data valid one cycle after the address
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_total <= wr_total + 1;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  // Issue one request and wait for its done pulse; lat = cycles from accept, -1 on timeout.
  task automatic issue(input bit use_if, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int rb_edge, input int io_clear,
                       output int lat, output logic [31:0] rdata, output int wcnt, output int other);
    int start;
    start = wr_total;
    lat = -1; rdata = 32'd0; other = 0;
    if (use_if) begin
      if_valid = 1'b1; if_addr = addr;
    end else begin
      lsb_valid = 1'b1; lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = data;
    end
    io_full = (io_clear > 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (use_if ? lsb_done : if_done) other++;
      if (use_if ? if_done : lsb_done) begin
        lat = k - 1;
        rdata = use_if ? if_data : lsb_rdata;
        break;
      end
      if (k == rb_edge) rollback = 1'b1;
      if (k == io_clear) io_full = 1'b0;
    end
    if_valid = 1'b0; lsb_valid = 1'b0; rollback = 1'b0; io_full = 1'b0;
    wcnt = wr_total - start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_clr = 1'b1; rollback = 1'b0; io_full = 1'b0;
    if_valid = 1'b0; if_addr = 32'd0; lsb_valid = 1'b0; lsb_wr = 1'b0;
    lsb_size = 2'b00; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({if_done, lsb_done, mem_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {if_done, lsb_done, mem_wr});
    end
    n_tests++;
    if ({if_data, lsb_rdata, mem_a, mem_dout} !== 104'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want zeros", if_data, lsb_rdata, mem_a, mem_dout);
    end
    ram_clr = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stores();
    int lat, wc, oth;
    logic [31:0] rd;
    issue(1'b0, 1'b1, 2'b00, 32'h200, 32'h0000_00AB, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 1 || wc !== 1) begin
      n_fail++; $display("FAIL sb: lat %0d writes %0d want 1 1", lat, wc);
    end
    issue(1'b0, 1'b1, 2'b01, 32'h202, 32'h0000_CDEF, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 2 || wc !== 2) begin
      n_fail++; $display("FAIL sh: lat %0d writes %0d want 2 2", lat, wc);
    end
    issue(1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 5 || rd !== 32'hCDEF_00AB || wc !== 0 || oth !== 0) begin
      n_fail++; $display("FAIL lw: lat %0d data %h writes %0d want 5 cdef00ab 0", lat, rd, wc);
    end
    issue(1'b0, 1'b0, 2'b00, 32'h203, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 2 || rd !== 32'h0000_00CD) begin
      n_fail++; $display("FAIL lb: lat %0d data %h want 2 000000cd", lat, rd);
    end
    issue(1'b0, 1'b0, 2'b01, 32'h202, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 3 || rd !== 32'h0000_CDEF) begin
      n_fail++; $display("FAIL lh: lat %0d data %h want 3 0000cdef", lat, rd);
    end
  endtask

  task automatic test_fetch();
    int lat, wc, oth;
    logic [31:0] rd;
    issue(1'b0, 1'b1, 2'b11, 32'h100, 32'h4433_2211, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 4 || wc !== 4 || ram[12'h100] !== 8'h11 || ram[12'h103] !== 8'h44) begin
      n_fail++; $display("FAIL sw_preload: lat %0d writes %0d b0 %h b3 %h want 4 4 11 44",
                         lat, wc, ram[12'h100], ram[12'h103]);
    end
    issue(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 5 || rd !== 32'h4433_2211 || oth !== 0) begin
      n_fail++; $display("FAIL fetch: lat %0d data %h lsb_done %0d want 5 44332211 0", lat, rd, oth);
    end
  endtask

  task automatic test_back_to_back();
    int who [3];
    int at [3];
    logic [31:0] dat [3];
    int n;
    n = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_valid = 1'b1; if_addr = 32'h100;
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h200;
    for (int k = 1; k <= 60 && n < 3; k++) begin
      @(posedge clk); #1;
      if (if_done && lsb_done) begin
        n_tests++; n_fail++; $display("FAIL dual_done: both done at cycle %0d want one", k);
      end
      if (if_done || lsb_done) begin
        who[n] = if_done ? 0 : 1;
        at[n] = k;
        dat[n] = if_done ? if_data : lsb_rdata;
        n++;
      end
    end
    if_valid = 1'b0; lsb_valid = 1'b0;
    n_tests++;
    if (n !== 3) begin
      n_fail++; $display("FAIL rr_count: got %0d dones want 3", n);
    end else begin
      n_tests++;
      if (who[0] !== 0 || who[1] !== 1 || who[2] !== 0) begin
        n_fail++; $display("FAIL rr_order: got %0d %0d %0d want 0 1 0 (0=IF)", who[0], who[1], who[2]);
      end
      n_tests++;
      if (at[1] - at[0] !== 6 || at[2] - at[1] !== 6) begin
        n_fail++; $display("FAIL rr_spacing: got %0d %0d want 6 6", at[1] - at[0], at[2] - at[1]);
      end
      n_tests++;
      if (dat[0] !== 32'h4433_2211 || dat[1] !== 32'hCDEF_00AB) begin
        n_fail++; $display("FAIL rr_data: got %h %h want 44332211 cdef00ab", dat[0], dat[1]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_rollback();
    int lat, wc, oth;
    logic [31:0] rd, a0;
    issue(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 2, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== -1 || oth !== 0) begin
      n_fail++; $display("FAIL rb_load: lat %0d if_done %0d want -1 (no done) 0", lat, oth);
    end
    issue(1'b0, 1'b1, 2'b10, 32'h300, 32'h1122_3344, 1, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 4 || wc !== 4 || ram[12'h300] !== 8'h44 || ram[12'h303] !== 8'h11) begin
      n_fail++; $display("FAIL rb_store: lat %0d writes %0d b0 %h b3 %h want 4 4 44 11",
                         lat, wc, ram[12'h300], ram[12'h303]);
    end
    a0 = mem_a;
    rollback = 1'b1; if_valid = 1'b1; if_addr = 32'h104;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (mem_a !== a0 || if_done !== 1'b0) begin
      n_fail++; $display("FAIL rb_idle: addr %h done %b want %h 0", mem_a, if_done, a0);
    end
    rollback = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 5 || rd !== 32'h4433_2211) begin
      n_fail++; $display("FAIL rb_recover: lat %0d data %h want 5 44332211", lat, rd);
    end
  endtask

  task automatic test_wrap_reset();
    int lat, wc, oth, start;
    logic [31:0] rd;
    issue(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'hD4C3_B2A1, 0, 0, lat, rd, wc, oth);
    issue(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 0, 0, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 5 || rd !== 32'hD4C3_B2A1 || ram[12'h000] !== 8'hC3 || ram[12'hFFE] !== 8'hA1) begin
      n_fail++; $display("FAIL wrap: lat %0d data %h b0 %h bffe %h want 5 d4c3b2a1 c3 a1",
                         lat, rd, ram[12'h000], ram[12'hFFE]);
    end
    start = wr_total;
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h400; lsb_wdata = 32'h5566_7788;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; lsb_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_wr: mem_wr %b want 0", mem_wr);
    end
    rst_n = 1'b1;
    oth = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (lsb_done || if_done) oth++;
    end
    n_tests++;
    if (oth !== 0 || wr_total - start !== 2 || ram[12'h400] !== 8'h88 || ram[12'h401] !== 8'h77
        || ram[12'h402] !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_partial: dones %0d writes %0d bytes %h %h %h want 0 2 88 77 00",
                         oth, wr_total - start, ram[12'h400], ram[12'h401], ram[12'h402]);
    end
  endtask

  task automatic test_io_stall();
    int lat, wc, oth, exp_lat;
    logic [31:0] rd;
`ifdef MEM_CTRL_IO_STALL_EN
    exp_lat = 4;
`else
    exp_lat = 1;
`endif
    issue(1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_005A, 0, 3, lat, rd, wc, oth);
    n_tests++;
    if (lat !== exp_lat || wc !== 1 || ram[12'h000] !== 8'h5A) begin
      n_fail++; $display("FAIL io_stall: lat %0d writes %0d byte %h want %0d 1 5a", lat, wc, ram[12'h000], exp_lat);
    end
    issue(1'b0, 1'b1, 2'b00, 32'h0002_0000, 32'h0000_00A5, 0, 3, lat, rd, wc, oth);
    n_tests++;
    if (lat !== 1 || wc !== 1 || ram[12'h000] !== 8'hA5) begin
      n_fail++; $display("FAIL io_nonio: lat %0d writes %0d byte %h want 1 1 a5", lat, wc, ram[12'h000]);
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_fetch();
    test_back_to_back();
    test_rollback();
    test_wrap_reset();
    test_io_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
